// File: rtl/uvmt_obi_st_slv_mem_pkg.sv
// ----------------------------------------------------------------------------
// uvmt_obi_st_slv_mem_pkg
// Shared types and constants for the OBI self-test slave memory.
//   rsp_t       : one buffered R-channel response {rdata, err, rid}
//   WORD_BYTES  : bytes per RAM word (byte-enable width)
//   mem_aw()    : word-index width for a given RAM depth
// Optional feature macro used by the slave: UVMT_OBI_ST_SLV_MEM_INTEGRITY_EN
// ----------------------------------------------------------------------------
package uvmt_obi_st_slv_mem_pkg;

    localparam int WORD_BYTES     = 4;
    localparam int RSP_DATA_WIDTH = 32;
    localparam int RSP_ID_WIDTH   = 4;

    // Field widths must match the DATA_WIDTH / ID_WIDTH used by the slave.
    typedef struct packed {
        logic [RSP_DATA_WIDTH-1:0] rdata;
        logic                      err;
        logic [RSP_ID_WIDTH-1:0]   rid;
    } rsp_t;

    // Width of the word index; a single-word RAM still needs a 1-bit index.
    function automatic int mem_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uvmt_obi_st_slv_mem_if.sv
// ----------------------------------------------------------------------------
// uvmt_obi_st_slv_mem_if
// OBI A/R channel bundle between the self-test DUT (master) and the slave
// memory (slave).
//   A channel : req, gnt, addr, we, be, wdata, aid, reqpar, gntpar
//   R channel : rvalid, rready, rdata, err, rid, exokay, rvalidpar, rreadypar
// Modports: master (drives A requests, consumes R), slave (the memory).
// ----------------------------------------------------------------------------
interface uvmt_obi_st_slv_mem_if
    import uvmt_obi_st_slv_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) ();

    logic                    req;
    logic                    gnt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    we;
    logic [WORD_BYTES-1:0]   be;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [ID_WIDTH-1:0]     aid;
    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    err;
    logic [ID_WIDTH-1:0]     rid;
    logic                    exokay;
    logic                    reqpar;
    logic                    gntpar;
    logic                    rvalidpar;
    logic                    rreadypar;

    modport master (
        output req, addr, we, be, wdata, aid, rready, reqpar, rreadypar,
        input  gnt, rvalid, rdata, err, rid, exokay, gntpar, rvalidpar
    );

    modport slave (
        input  req, addr, we, be, wdata, aid, rready, reqpar, rreadypar,
        output gnt, rvalid, rdata, err, rid, exokay, gntpar, rvalidpar
    );

endinterface

// File: rtl/uvmt_obi_st_rsp_fifo.sv
// ----------------------------------------------------------------------------
// uvmt_obi_st_rsp_fifo
// Synchronous FIFO of rsp_t entries holding in-order R-channel responses.
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset (empties FIFO)
//   i_push, i_push_data   : write an entry (ignored when full)
//   i_pop                 : remove the head entry (ignored when empty)
//   o_pop_data            : current head entry
//   o_full, o_empty       : occupancy flags
//   o_count               : number of stored entries (registered)
// ----------------------------------------------------------------------------
module uvmt_obi_st_rsp_fifo
    import uvmt_obi_st_slv_mem_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_push,
    input  rsp_t          i_push_data,
    input  logic          i_pop,
    output rsp_t          o_pop_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    rsp_t          r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    // Explicit wrap keeps non-power-of-two depths and DEPTH=1 correct.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];
    assign w_do_push  = i_push & ~o_full;
    assign w_do_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible between push and pop.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/uvmt_obi_st_slv_mem.sv
// ----------------------------------------------------------------------------
// uvmt_obi_st_slv_mem
// OBI slave memory for closed-loop self-test. Accepts A-channel requests into
// a word-addressed RAM with byte enables and returns in-order responses on
// the R channel through a MAX_OUTSTANDING-deep response FIFO.
// Ports:
//   clk      : clock
//   reset_n  : synchronous active-low reset (flushes responses, RAM kept)
//   bus      : uvmt_obi_st_slv_mem_if.slave (A and R channel signals)
// Optional feature: define UVMT_OBI_ST_SLV_MEM_INTEGRITY_EN to enable the
// parity outputs and the sticky integrity-error flag; otherwise gntpar and
// rvalidpar are constant 1 and reqpar/rreadypar are ignored.
// ----------------------------------------------------------------------------
module uvmt_obi_st_slv_mem
    import uvmt_obi_st_slv_mem_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 4,
    parameter int MEM_DEPTH       = 1024,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    uvmt_obi_st_slv_mem_if.slave    bus
);

    localparam int MEM_AW      = mem_aw(MEM_DEPTH);
    localparam int RANGE_SHIFT = $clog2(MEM_DEPTH * WORD_BYTES);
    localparam int CW          = $clog2(MAX_OUTSTANDING) + 1;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic                  w_gnt;
    logic                  w_accept;
    logic                  w_in_range;
    logic [MEM_AW-1:0]     w_word_idx;
    logic                  w_wr_en;
    logic                  w_integ_err;
    logic [DATA_WIDTH-1:0] w_rd_word;
    rsp_t                  w_rsp;
    rsp_t                  w_head;
    logic                  w_full;
    logic                  w_empty;
    logic [CW-1:0]         w_count;

    // ---------------- A channel: grant and decode ----------------
    // Grant only looks at the registered occupancy, never at rready, so a
    // pop in the same cycle as a full FIFO does not re-open the grant.
    assign w_gnt      = bus.req & reset_n & (w_count < CW'(MAX_OUTSTANDING));
    assign w_accept   = bus.req & w_gnt;
    assign w_in_range = ((bus.addr >> RANGE_SHIFT) == '0);
    assign w_word_idx = bus.addr[2 +: MEM_AW];
    assign w_wr_en    = w_accept & bus.we & w_in_range & ~w_integ_err;

    assign bus.gnt    = w_gnt;
    assign bus.exokay = 1'b0;

    // ---------------- RAM ----------------
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (bus.be[b]) r_mem[w_word_idx][b*8 +: 8] <= bus.wdata[b*8 +: 8];
            end
        end
    end

    // The read word is captured into the response FIFO at the accept edge,
    // so the FIFO entry acts as the registered RAM output and the response
    // is visible on the next cycle.
    assign w_rd_word = r_mem[w_word_idx];

    always_comb begin
        w_rsp       = '0;
        w_rsp.rid   = bus.aid;
        w_rsp.err   = ~w_in_range | w_integ_err;
        if (!bus.we && w_in_range && !w_integ_err) begin
            w_rsp.rdata = w_rd_word;
        end
    end

    // ---------------- Response FIFO ----------------
    uvmt_obi_st_rsp_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_rsp_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_accept),
        .i_push_data (w_rsp),
        .i_pop       (bus.rready),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    // Outputs are forced to zero while empty so idle R fields are clean.
    assign bus.rvalid = ~w_empty;
    assign bus.rdata  = w_empty ? '0 : w_head.rdata;
    assign bus.err    = w_empty ? 1'b0 : w_head.err;
    assign bus.rid    = w_empty ? '0 : w_head.rid;

    // ---------------- Integrity ----------------
`ifdef UVMT_OBI_ST_SLV_MEM_INTEGRITY_EN
    logic r_integ_err;

    // A parity input equal to its signal is a broken pair; once seen, the
    // slave stays in error mode until reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_integ_err <= 1'b0;
        end else if ((bus.reqpar == bus.req) || (bus.rreadypar == bus.rready)) begin
            r_integ_err <= 1'b1;
        end
    end

    assign w_integ_err   = r_integ_err;
    assign bus.gntpar    = ~w_gnt;
    assign bus.rvalidpar = w_empty;
`else
    logic w_unused_par;

    assign w_unused_par  = bus.reqpar ^ bus.rreadypar;
    assign w_integ_err   = 1'b0;
    assign bus.gntpar    = 1'b1;
    assign bus.rvalidpar = 1'b1;
`endif

    logic w_unused_full;
    assign w_unused_full = w_full;

endmodule

// File: tb/tb_uvmt_obi_st_slv_mem.sv
// ----------------------------------------------------------------------------
// tb_uvmt_obi_st_slv_mem
// Self-checking bench for uvmt_obi_st_slv_mem. A behavioural model (byte
// array + expected-response queue) predicts every response at the moment a
// request is granted; a recorder collects responses taken on the R channel.
// Honours UVMT_OBI_ST_SLV_MEM_INTEGRITY_EN for the parity checks.
// ----------------------------------------------------------------------------
module tb_uvmt_obi_st_slv_mem;
    import uvmt_obi_st_slv_mem_pkg::*;

    localparam int MEM_DEPTH = 1024;
    localparam int MAX_OUT   = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic par_bad = 1'b0;
    logic rand_rready = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uvmt_obi_st_slv_mem_if bus_if ();

    uvmt_obi_st_slv_mem #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .ID_WIDTH        (4),
        .MEM_DEPTH       (MEM_DEPTH),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    // Parity inputs are correct (inverted) unless a test breaks them.
    assign bus_if.reqpar    = par_bad ? bus_if.req : ~bus_if.req;
    assign bus_if.rreadypar = ~bus_if.rready;

    // ---------------- reference model ----------------
    logic [31:0] model_mem [MEM_DEPTH];
    bit          model_flag = 1'b0;
    rsp_t        exp_q [$];
    rsp_t        obs_q [$];

    function automatic void model_accept(input bit w, input logic [31:0] a,
                                         input logic [3:0] b, input logic [31:0] d,
                                         input logic [3:0] id);
        rsp_t r;
        int   idx;
        r = '0;
        r.rid = id;
        if (model_flag || a >= 32'(MEM_DEPTH * WORD_BYTES)) begin
            r.err = 1'b1;
        end else begin
            idx = int'(a >> 2);
            if (w) begin
                for (int k = 0; k < 4; k++)
                    if (b[k]) model_mem[idx][k*8 +: 8] = d[k*8 +: 8];
            end else begin
                r.rdata = model_mem[idx];
            end
        end
        exp_q.push_back(r);
        $display("txn we=%0b addr=%h be=%h wdata=%h aid=%0d -> rdata=%h err=%0b",
                 w, a, b, d, id, r.rdata, r.err);
    endfunction

    // Record each response taken on the R channel (it pops at the next edge).
    always @(negedge clk) begin
        if (reset_n && bus_if.rvalid && bus_if.rready)
            obs_q.push_back('{rdata: bus_if.rdata, err: bus_if.err, rid: bus_if.rid});
    end

    always @(posedge clk) begin
        #1;
        if (rand_rready) bus_if.rready = 1'($urandom_range(0, 1));
    end

    // ---------------- driver helpers (called just after a posedge) ----------------
    task automatic issue(input bit w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, input logic [3:0] id);
        bus_if.req = 1'b1; bus_if.we = w; bus_if.addr = a;
        bus_if.be = b; bus_if.wdata = d; bus_if.aid = id;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus_if.gnt) begin
                model_accept(w, a, b, d, id);
                @(posedge clk); #1;
                bus_if.req = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        checks++; failures++;
        $display("FAIL grant_timeout got gnt=0 for 200 cycles need gnt=1 addr=%h", a);
        bus_if.req = 1'b0;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 1000; c++) begin
            if (obs_q.size() >= exp_q.size()) return;
            @(posedge clk); #1;
        end
        checks++; failures++;
        $display("FAIL drain_timeout got=%0d responses need=%0d", obs_q.size(), exp_q.size());
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0; bus_if.req = 1'b1; bus_if.rready = 1'b0;
        bus_if.we = 1'b0; bus_if.addr = '0; bus_if.be = '0; bus_if.wdata = '0; bus_if.aid = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus_if.gnt, bus_if.rvalid, bus_if.err, bus_if.exokay} !== 4'b0000 ||
            bus_if.rdata !== 32'h0 || bus_if.rid !== 4'h0) begin
            failures++;
            $display("FAIL reset_state got gnt=%b rvalid=%b err=%b exokay=%b rdata=%h rid=%h need all 0",
                     bus_if.gnt, bus_if.rvalid, bus_if.err, bus_if.exokay, bus_if.rdata, bus_if.rid);
        end
        @(posedge clk); #1;
        reset_n = 1'b1; bus_if.req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        rsp_t e, o;
        bus_if.rready = 1'b1;
        issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 4'd1);
        @(negedge clk);
        checks++;
        if (bus_if.rvalid !== 1'b1) begin
            failures++; $display("FAIL write_latency got rvalid=%b need 1", bus_if.rvalid);
        end
        @(posedge clk); #1;
        issue(1'b0, 32'h10, 4'h0, 32'h0, 4'd2);
        @(negedge clk);
        checks++;
        if (bus_if.rvalid !== 1'b1 || bus_if.rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL read_latency got rvalid=%b rdata=%h need 1 DEADBEEF", bus_if.rvalid, bus_if.rdata);
        end
        @(posedge clk); #1;
        issue(1'b1, 32'h10, 4'h1, 32'h000000AA, 4'd3);
        issue(1'b0, 32'h12, 4'h0, 32'h0, 4'd4);
        wait_drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL basic_rsp got none need rid=%0d", e.rid);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL basic_rsp got rdata=%h err=%b rid=%0d need rdata=%h err=%b rid=%0d",
                             o.rdata, o.err, o.rid, e.rdata, e.err, e.rid);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        rsp_t e, o;
        int   grants = 0;
        bit   gnt_seen;
        logic [3:0] id = 4'd0;
        bus_if.rready = 1'b0;
        bus_if.req = 1'b1; bus_if.we = 1'b0; bus_if.addr = 32'h10; bus_if.be = 4'hF; bus_if.aid = id;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            gnt_seen = bus_if.gnt;
            if (gnt_seen) begin model_accept(1'b0, 32'h10, 4'hF, 32'h0, id); grants++; end
            @(posedge clk); #1;
            if (gnt_seen) begin id = id + 4'd1; bus_if.aid = id; end
        end
        checks++;
        if (grants != MAX_OUT || gnt_seen) begin
            failures++; $display("FAIL full_grants got=%0d last_gnt=%b need=%0d last_gnt=0", grants, gnt_seen, MAX_OUT);
        end
        bus_if.rready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_if.gnt !== 1'b0 || bus_if.rvalid !== 1'b1 || bus_if.rid !== 4'd0) begin
            failures++;
            $display("FAIL full_pop_cycle got gnt=%b rvalid=%b rid=%0d need gnt=0 rvalid=1 rid=0",
                     bus_if.gnt, bus_if.rvalid, bus_if.rid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus_if.gnt !== 1'b1) begin
            failures++; $display("FAIL gnt_after_pop got gnt=%b need 1", bus_if.gnt);
        end
        if (bus_if.gnt) model_accept(1'b0, 32'h10, 4'hF, 32'h0, id);
        @(posedge clk); #1;
        bus_if.req = 1'b0;
        issue(1'b0, 32'h10, 4'hF, 32'h0, 4'd5);
        wait_drain();
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL order_rsp got none need rid=%0d", e.rid);
            end else begin
                o = obs_q.pop_front();
                if (o !== e || o.rid !== 4'(i)) begin
                    failures++;
                    $display("FAIL order_rsp got rdata=%h err=%b rid=%0d need rdata=%h err=%b rid=%0d",
                             o.rdata, o.err, o.rid, e.rdata, e.err, i);
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        rsp_t e, o;
        bus_if.rready = 1'b1;
        issue(1'b1, 32'h0, 4'hF, 32'h12345678, 4'd1);
        issue(1'b0, 32'h1000, 4'hF, 32'h0, 4'd5);
        issue(1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, 4'd6);
        issue(1'b1, 32'h4, 4'h0, 32'hFFFFFFFF, 4'd7);
        issue(1'b0, 32'h0, 4'h0, 32'h0, 4'd8);
        wait_drain();
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL oor_rsp got none need rid=%0d", e.rid);
            end else begin
                o = obs_q.pop_front();
                if (o !== e || (i == 1 && {o.err, o.rdata, o.rid} !== {1'b1, 32'h0, 4'd5})) begin
                    failures++;
                    $display("FAIL oor_rsp got rdata=%h err=%b rid=%0d need rdata=%h err=%b rid=%0d",
                             o.rdata, o.err, o.rid, e.rdata, e.err, e.rid);
                end
            end
        end
    endtask

    task automatic test_reset_flush();
        rsp_t e, o;
        bus_if.rready = 1'b0;
        for (int i = 0; i < 3; i++) issue(1'b0, 32'h10, 4'hF, 32'h0, 4'(i));
        bus_if.req = 1'b1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus_if.rvalid !== 1'b0 || bus_if.gnt !== 1'b0) begin
            failures++; $display("FAIL flush_state got rvalid=%b gnt=%b need 0 0", bus_if.rvalid, bus_if.gnt);
        end
        @(posedge clk); #1;
        reset_n = 1'b1; bus_if.req = 1'b0;
        exp_q.delete(); obs_q.delete(); model_flag = 1'b0;
        @(posedge clk); #1;
        bus_if.rready = 1'b1;
        issue(1'b0, 32'h10, 4'hF, 32'h0, 4'd9);
        wait_drain();
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (exp_q.size() != 1 || obs_q.size() != 1) begin
            failures++; $display("FAIL flush_count got=%0d responses need=1", obs_q.size());
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o !== e) begin
                failures++;
                $display("FAIL flush_rsp got rdata=%h err=%b rid=%0d need rdata=%h err=%b rid=%0d",
                         o.rdata, o.err, o.rid, e.rdata, e.err, e.rid);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_random();
        rsp_t e, o;
        logic [31:0] a;
        bus_if.rready = 1'b1;
        for (int i = 0; i < 16; i++) issue(1'b1, 32'(i * 4), 4'hF, $urandom(), 4'(i));
        rand_rready = 1'b1;
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'h1000 + $urandom_range(0, 4095);
                1:       a = $urandom() | 32'h0001_0000;
                default: a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            endcase
            issue(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom(), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        rand_rready = 1'b0;
        @(posedge clk); #1;
        bus_if.rready = 1'b1;
        wait_drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL random_rsp got none need rid=%0d", e.rid);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL random_rsp got rdata=%h err=%b rid=%0d need rdata=%h err=%b rid=%0d",
                             o.rdata, o.err, o.rid, e.rdata, e.err, e.rid);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0 || bus_if.rvalid !== 1'b0) begin
            failures++; $display("FAIL random_extra got=%0d leftover rvalid=%b need 0 0", obs_q.size(), bus_if.rvalid);
        end
    endtask

    task automatic test_parity();
        rsp_t e, o;
        bit   bad = 1'b0;
        bus_if.rready = 1'b0;
        bus_if.we = 1'b0; bus_if.addr = 32'h10; bus_if.be = 4'hF; bus_if.aid = 4'd3;
        for (int c = 0; c < 24; c++) begin
            bus_if.req = 1'($urandom_range(0, 1));
            if (c == 12) bus_if.rready = 1'b1;
            @(negedge clk);
`ifdef UVMT_OBI_ST_SLV_MEM_INTEGRITY_EN
            if (bus_if.gntpar !== ~bus_if.gnt || bus_if.rvalidpar !== ~bus_if.rvalid) bad = 1'b1;
`else
            if (bus_if.gntpar !== 1'b1 || bus_if.rvalidpar !== 1'b1) bad = 1'b1;
`endif
            if (bus_if.req && bus_if.gnt) model_accept(1'b0, 32'h10, 4'hF, 32'h0, 4'd3);
            @(posedge clk); #1;
        end
        bus_if.req = 1'b0;
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL parity_outputs got gntpar=%b rvalidpar=%b at a cycle need the configured parity",
                     bus_if.gntpar, bus_if.rvalidpar);
        end
`ifdef UVMT_OBI_ST_SLV_MEM_INTEGRITY_EN
        par_bad = 1'b1;
        @(posedge clk); #1;
        par_bad = 1'b0;
        model_flag = 1'b1;
`endif
        issue(1'b1, 32'h10, 4'hF, 32'h55555555, 4'd10);
        issue(1'b0, 32'h10, 4'hF, 32'h0, 4'd11);
        wait_drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL parity_rsp got none need rid=%0d", e.rid);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL parity_rsp got rdata=%h err=%b rid=%0d need rdata=%h err=%b rid=%0d",
                             o.rdata, o.err, o.rid, e.rdata, e.err, e.rid);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) model_mem[i] = 32'h0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_out_of_range();
        test_reset_flush();
        test_random();
        test_parity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got no finish need finish before 2ms");
        $fatal(1, "timeout");
    end

endmodule
